// File: rtl/blram_dma.sv
// Block-copy / fill engine acting as sole initiator on the blram single port.
// Copy alternates RD/WR cycles to absorb the RAM's registered read latency.
module blram_dma #(
   parameter int SIZE  = 6,
   parameter int DEPTH = 64,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_mode,
   input  logic [SIZE-1:0]  i_src,
   input  logic [SIZE-1:0]  i_dst,
   input  logic [SIZE:0]    i_len,
   input  logic [WIDTH-1:0] i_fill,
   output logic             o_busy,
   output logic             o_done,
   output logic [SIZE:0]    o_count,
   output logic             o_ram_we,
   output logic [SIZE-1:0]  o_ram_addr,
   output logic [WIDTH-1:0] o_ram_data,
   input  logic [WIDTH-1:0] i_ram_data
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      FILL,
      DONE
   } state_t;

   localparam logic [SIZE:0] DEPTH_L = (SIZE+1)'(DEPTH);

   state_t           state;
   state_t           state_n;
   logic [SIZE-1:0]  src_q;
   logic [SIZE-1:0]  dst_q;
   logic [SIZE:0]    len_q;
   logic [SIZE:0]    k_q;
   logic [SIZE:0]    count_q;
   logic [WIDTH-1:0] fill_q;

   logic [SIZE:0]    len_c;
   logic [SIZE:0]    k_inc;
   logic             last;

   assign len_c   = (i_len > DEPTH_L) ? DEPTH_L : i_len;
   assign k_inc   = k_q + 1'b1;
   assign last    = (k_inc == len_q);
   assign o_count = count_q;

   // The command mode is carried by the state itself (RD/WR vs FILL).
   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (i_start) begin
               if (len_c == '0)
                  state_n = DONE;
               else if (i_mode)
                  state_n = FILL;
               else
                  state_n = RD;
            end
         end
         RD:      state_n = WR;
         WR:      state_n = last ? DONE : RD;
         FILL:    state_n = last ? DONE : FILL;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      o_busy     = (state != IDLE);
      o_done     = (state == DONE);
      o_ram_we   = 1'b0;
      o_ram_addr = '0;
      o_ram_data = '0;
      case (state)
         RD: begin
            o_ram_addr = src_q + k_q[SIZE-1:0];
         end
         WR: begin
            o_ram_we   = 1'b1;
            o_ram_addr = dst_q + k_q[SIZE-1:0];
            o_ram_data = i_ram_data;
         end
         FILL: begin
            o_ram_we   = 1'b1;
            o_ram_addr = dst_q + k_q[SIZE-1:0];
            o_ram_data = fill_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         k_q     <= '0;
         count_q <= '0;
         fill_q  <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (i_start) begin
                  src_q   <= i_src;
                  dst_q   <= i_dst;
                  len_q   <= len_c;
                  fill_q  <= i_fill;
                  k_q     <= '0;
                  count_q <= '0;
               end
            end
            WR, FILL: begin
               k_q     <= k_inc;
               count_q <= count_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_blram_dma.sv
// Self-checking bench for blram_dma: behavioural RAM, array reference model,
// directed test-plan cases followed by randomized commands.
`timescale 1ns/1ps
module tb_blram_dma;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_start;
   logic       i_mode;
   logic [5:0] i_src;
   logic [5:0] i_dst;
   logic [6:0] i_len;
   logic [9:0] i_fill;
   logic       o_busy;
   logic       o_done;
   logic [6:0] o_count;
   logic       o_ram_we;
   logic [5:0] o_ram_addr;
   logic [9:0] o_ram_data;
   logic [9:0] ram_q;

   logic       bw_en;
   logic [5:0] bw_addr;
   logic [9:0] bw_data;

   logic [9:0] mem [64];
   logic [9:0] ref_mem [64];

   int checks = 0;
   int errors = 0;

   int we_cnt = 0;
   int busy_cnt = 0;
   int done_cnt = 0;
   int viol_cnt = 0;

   always #5 clk = ~clk;

   blram_dma #(.SIZE(6), .DEPTH(64), .WIDTH(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_mode     (i_mode),
      .i_src      (i_src),
      .i_dst      (i_dst),
      .i_len      (i_len),
      .i_fill     (i_fill),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_count    (o_count),
      .o_ram_we   (o_ram_we),
      .o_ram_addr (o_ram_addr),
      .o_ram_data (o_ram_data),
      .i_ram_data (ram_q)
   );

   // Behavioural blram: write at the edge, registered read of the old contents.
   always @(posedge clk) begin
      if (o_ram_we)
         mem[o_ram_addr] <= o_ram_data;
      else if (bw_en)
         mem[bw_addr] <= bw_data;
      ram_q <= mem[o_ram_addr];
   end

   // Free-running activity monitor; the bench takes deltas around each command.
   always @(negedge clk) begin
      if (o_ram_we === 1'b1) we_cnt <= we_cnt + 1;
      if (o_busy === 1'b1)   busy_cnt <= busy_cnt + 1;
      if (o_done === 1'b1)   done_cnt <= done_cnt + 1;
      if (o_ram_we !== 1'b1 && o_ram_data !== 10'd0) viol_cnt <= viol_cnt + 1;
      if ((o_busy !== 1'b1 || o_done === 1'b1) &&
          (o_ram_we !== 1'b0 || o_ram_addr !== 6'd0 || o_ram_data !== 10'd0))
         viol_cnt <= viol_cnt + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [5:0] a, input logic [9:0] d);
      @(negedge clk);
      bw_en   = 1'b1;
      bw_addr = a;
      bw_data = d;
      ref_mem[a] = d;
      @(negedge clk);
      bw_en = 1'b0;
   endtask

   task automatic cmp_ram(input string tag);
      int mism;
      mism = 0;
      for (int i = 0; i < 64; i++)
         if (mem[i] !== ref_mem[i]) mism++;
      chk(tag, mism, 0);
   endtask

   task automatic run_cmd(input string tag, input logic mode, input logic [5:0] src,
                          input logic [5:0] dst, input logic [6:0] len,
                          input logic [9:0] fill, input bit poke);
      int L, exp_n, cyc, we0, busy0, done0, viol0;
      logic [5:0] a, b;
      L = (len > 7'd64) ? 64 : int'(len);
      exp_n = (L == 0) ? 1 : (mode ? L + 1 : 2 * L + 1);
      for (int i = 0; i < L; i++) begin
         a = dst + 6'(i);
         b = src + 6'(i);
         ref_mem[a] = mode ? fill : ref_mem[b];
      end

      @(negedge clk);
      we0 = we_cnt; busy0 = busy_cnt; done0 = done_cnt; viol0 = viol_cnt;
      i_mode = mode; i_src = src; i_dst = dst; i_len = len; i_fill = fill;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      cyc = 1;
      while (o_done !== 1'b1 && cyc < 400) begin
         if (poke && cyc == 1) begin
            i_start = 1'b1;
            i_mode  = ~mode;
            i_dst   = dst + 6'd5;
            i_len   = 7'd9;
            i_fill  = ~fill;
         end else begin
            i_start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_done_cycle"}, cyc, exp_n);
      if (poke) i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk({tag, "_busy_after"}, int'(o_busy), 0);
      chk({tag, "_count"}, int'(o_count), L);
      chk({tag, "_writes"}, we_cnt - we0, L);
      chk({tag, "_busy_cycles"}, busy_cnt - busy0, exp_n);
      chk({tag, "_done_pulses"}, done_cnt - done0, 1);
      chk({tag, "_idle_outputs"}, viol_cnt - viol0, 0);
      cmp_ram({tag, "_ram"});
   endtask

   initial begin
      int w0, d0;
      rst = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_src = '0; i_dst = '0;
      i_len = '0; i_fill = '0; bw_en = 1'b0; bw_addr = '0; bw_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_done", int'(o_done), 0);
      chk("rst_count", int'(o_count), 0);
      chk("rst_we", int'(o_ram_we), 0);
      chk("rst_addr", int'(o_ram_addr), 0);
      chk("rst_data", int'(o_ram_data), 0);
      rst = 1'b1;

      for (int i = 0; i < 64; i++) load_word(6'(i), 10'($urandom));

      run_cmd("fill10", 1'b1, 6'd0, 6'd10, 7'd4, 10'h2AA, 1'b0);
      chk("fill10_word14_kept", int'(mem[14] === 10'h2AA && ref_mem[14] !== 10'h2AA), 0);

      load_word(6'd0, 10'h001); load_word(6'd1, 10'h002); load_word(6'd2, 10'h003);
      run_cmd("copy_disjoint", 1'b0, 6'd0, 6'd32, 7'd3, 10'h000, 1'b0);
      chk("copy_disjoint_w34", int'(mem[34]), 3);

      load_word(6'd0, 10'h0A1); load_word(6'd1, 10'h0B2);
      load_word(6'd2, 10'h0C3); load_word(6'd3, 10'h0D4);
      run_cmd("copy_overlap", 1'b0, 6'd0, 6'd1, 7'd3, 10'h000, 1'b0);
      chk("overlap_w0", int'(mem[0]), 'h0A1);
      chk("overlap_w3", int'(mem[3]), 'h0A1);

      run_cmd("fill_wrap", 1'b1, 6'd0, 6'd62, 7'd3, 10'h3C3, 1'b0);
      chk("fill_wrap_w0", int'(mem[0]), 'h3C3);
      run_cmd("fill_clamp", 1'b1, 6'd0, 6'd5, 7'd100, 10'h111, 1'b0);
      run_cmd("copy_clamp", 1'b0, 6'd9, 6'd40, 7'd127, 10'h000, 1'b0);
      run_cmd("len0_fill", 1'b1, 6'd0, 6'd7, 7'd0, 10'h155, 1'b0);
      run_cmd("len0_copy", 1'b0, 6'd3, 6'd7, 7'd0, 10'h000, 1'b0);
      run_cmd("len64_fill", 1'b1, 6'd0, 6'd33, 7'd64, 10'h2F0, 1'b0);

      for (int i = 0; i < 64; i++) load_word(6'(i), 10'($urandom));
      run_cmd("poke_copy", 1'b0, 6'd4, 6'd40, 7'd6, 10'h000, 1'b1);
      run_cmd("poke_fill", 1'b1, 6'd0, 6'd50, 7'd1, 10'h0F0, 1'b1);

      for (int n = 0; n < 10; n++) begin
         logic [6:0] l;
         l = ($urandom % 4 == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 8));
         run_cmd($sformatf("rand%0d", n), 1'($urandom), 6'($urandom), 6'($urandom),
                 l, 10'($urandom), 1'b0);
      end

      // Reset lands on the edge that also commits the 2nd of 5 fill words.
      @(negedge clk);
      w0 = we_cnt; d0 = done_cnt;
      ref_mem[20] = 10'h155; ref_mem[21] = 10'h155;
      i_mode = 1'b1; i_dst = 6'd20; i_len = 7'd5; i_fill = 10'h155; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(o_busy), 0);
      chk("abort_done", int'(o_done), 0);
      chk("abort_count", int'(o_count), 0);
      chk("abort_we", int'(o_ram_we), 0);
      chk("abort_addr", int'(o_ram_addr), 0);
      chk("abort_data", int'(o_ram_data), 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_writes", we_cnt - w0, 2);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_idle", int'(o_busy), 0);
      cmp_ram("abort_ram");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
